// File: rtl/exe_mem_stage.sv
// rtl/exe_mem_stage.sv - miCPU execute stage with one-entry EX/MEM slot and data-memory handshake
//
// Purpose:
//   Evaluates the ALU operation on the registered ID/EX operands, resolves
//   branches at the capture edge, holds the instruction in a one-entry slot,
//   runs a req/ack transaction to data memory for loads/stores (stalling
//   upstream while it waits), and presents registered write-back outputs.
//
// Optional feature macro: EXE_OVF_TRAP_EN
//   Defined   : signed ADD/SUB overflow sets sticky ovf_out and suppresses
//               the register write of the overflowing instruction.
//   Undefined : arithmetic wraps silently, ovf_out is tied 0.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   valid_in                      ID/EX holds a real instruction
//   wen_in, branch_in,
//   mem_to_reg_in, mem_write_in,
//   mem_read_in                   ID/EX control bits
//   nPC_in [ISIZE]                PC+1 of the instruction
//   imm_extended_in [DSIZE]       sign-extended immediate
//   alu_in1, alu_in2 [DSIZE]      ALU operands
//   rdata2_in [DSIZE]             store data
//   opcode_in [3]                 ALU operation
//   waddr_in [ASIZE]              destination register
//   stall_out                     hold IF/ID and ID/EX (combinational)
//   branch_taken_out              one-cycle taken pulse
//   branch_target_out [ISIZE]     nPC + imm, valid with the pulse
//   dmem_req, dmem_we             memory request, 1 = store
//   dmem_addr, dmem_wdata [DSIZE] memory address, store data
//   dmem_ack, dmem_rdata [DSIZE]  request completes, load data
//   wb_valid, wb_wen              write-back strobe, register write enable
//   wb_waddr [ASIZE], wb_data [DSIZE]
//   ovf_out                       sticky overflow flag

`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef ASIZE
`define ASIZE 5
`endif

module exe_mem_stage #(
  parameter int DSIZE = `DSIZE,
  parameter int ISIZE = `ISIZE,
  parameter int ASIZE = `ASIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             wen_in,
  input  logic             branch_in,
  input  logic             mem_to_reg_in,
  input  logic             mem_write_in,
  input  logic             mem_read_in,
  input  logic [ISIZE-1:0] nPC_in,
  input  logic [DSIZE-1:0] imm_extended_in,
  input  logic [DSIZE-1:0] alu_in1,
  input  logic [DSIZE-1:0] alu_in2,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [2:0]       opcode_in,
  input  logic [ASIZE-1:0] waddr_in,
  output logic             stall_out,
  output logic             branch_taken_out,
  output logic [ISIZE-1:0] branch_target_out,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DSIZE-1:0] dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic             wb_valid,
  output logic             wb_wen,
  output logic [ASIZE-1:0] wb_waddr,
  output logic [DSIZE-1:0] wb_data,
  output logic             ovf_out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;

  // EX/MEM slot
  logic             slot_valid_q, slot_valid_d;
  logic             slot_wen_q, slot_wen_d;
  logic             slot_mem_to_reg_q, slot_mem_to_reg_d;
  logic             slot_mem_write_q, slot_mem_write_d;
  logic [DSIZE-1:0] slot_result_q, slot_result_d;
  logic [DSIZE-1:0] slot_rdata2_q, slot_rdata2_d;
  logic [ASIZE-1:0] slot_waddr_q, slot_waddr_d;

  // Branch resolution
  logic             squash_q, squash_d;
  logic             branch_taken_q, branch_taken_d;
  logic [ISIZE-1:0] branch_target_q, branch_target_d;

  // Write-back registers
  logic             wb_valid_q, wb_valid_d;
  logic             wb_wen_q, wb_wen_d;
  logic [ASIZE-1:0] wb_waddr_q, wb_waddr_d;
  logic [DSIZE-1:0] wb_data_q, wb_data_d;

`ifdef EXE_OVF_TRAP_EN
  logic             slot_ovf_q, slot_ovf_d;
  logic             ovf_q, ovf_d;
  logic             alu_ovf;
`endif

  logic [DSIZE-1:0] alu_res;
  logic             busy;
  logic             capture;
  logic             in_valid;
  logic             in_taken;
  logic             retire;
  logic             retire_trap;

  // ALU
  always_comb begin
    alu_res = '0;
    case (opcode_in)
      3'b000: alu_res = alu_in1 + alu_in2;
      3'b001: alu_res = alu_in1 - alu_in2;
      3'b010: alu_res = alu_in1 & alu_in2;
      3'b011: alu_res = alu_in1 | alu_in2;
      3'b100: alu_res = alu_in1 ^ alu_in2;
      3'b101: alu_res = {{(DSIZE-1){1'b0}}, ($signed(alu_in1) < $signed(alu_in2))};
      3'b110: alu_res = alu_in1 << alu_in2[3:0];
      3'b111: alu_res = alu_in1 >> alu_in2[3:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EXE_OVF_TRAP_EN
  // Signed overflow: operands of the effective same sign give a result of
  // the opposite sign. SUB flips the sign of the second operand.
  always_comb begin
    alu_ovf = 1'b0;
    if (opcode_in == 3'b000) begin
      alu_ovf = (alu_in1[DSIZE-1] == alu_in2[DSIZE-1]) &&
                (alu_res[DSIZE-1] != alu_in1[DSIZE-1]);
    end else if (opcode_in == 3'b001) begin
      alu_ovf = (alu_in1[DSIZE-1] != alu_in2[DSIZE-1]) &&
                (alu_res[DSIZE-1] != alu_in1[DSIZE-1]);
    end
  end
`endif

  // Handshake and stall. The slot only ever holds a valid memory
  // instruction while BUSY, so in IDLE a valid slot is an ALU/branch op.
  always_comb begin
    busy       = (state_q == BUSY);
    stall_out  = busy & ~dmem_ack;
    capture    = ~stall_out;
    in_valid   = valid_in & ~squash_q;
    in_taken   = in_valid & branch_in & (alu_res == '0);
    retire     = slot_valid_q & (busy ? dmem_ack : 1'b1);
    dmem_req   = busy;
    dmem_we    = busy & slot_mem_write_q;
    dmem_addr  = busy ? slot_result_q : '0;
    dmem_wdata = busy ? slot_rdata2_q : '0;
  end

`ifdef EXE_OVF_TRAP_EN
  assign retire_trap = slot_ovf_q;
`else
  assign retire_trap = 1'b0;
`endif

  // Next-state: FSM, slot capture, branch pulse and write-back
  always_comb begin
    state_d           = state_q;
    slot_valid_d      = slot_valid_q;
    slot_wen_d        = slot_wen_q;
    slot_mem_to_reg_d = slot_mem_to_reg_q;
    slot_mem_write_d  = slot_mem_write_q;
    slot_result_d     = slot_result_q;
    slot_rdata2_d     = slot_rdata2_q;
    slot_waddr_d      = slot_waddr_q;
    squash_d          = squash_q;
    branch_taken_d    = 1'b0;
    branch_target_d   = '0;
    wb_valid_d        = 1'b0;
    wb_wen_d          = 1'b0;
    wb_waddr_d        = wb_waddr_q;
    wb_data_d         = wb_data_q;
`ifdef EXE_OVF_TRAP_EN
    slot_ovf_d        = slot_ovf_q;
    ovf_d             = ovf_q;
`endif

    if (capture) begin
      slot_valid_d      = in_valid;
      slot_wen_d        = wen_in;
      slot_mem_to_reg_d = mem_to_reg_in;
      slot_mem_write_d  = mem_write_in;
      slot_result_d     = alu_res;
      slot_rdata2_d     = rdata2_in;
      slot_waddr_d      = waddr_in;
      branch_taken_d    = in_taken;
      branch_target_d   = in_taken ? (nPC_in + imm_extended_in[ISIZE-1:0]) : '0;
      // Squash persists until the next capture so a stall cannot let the
      // wrong-path instruction slip through.
      squash_d          = in_taken;
      state_d           = (in_valid & (mem_read_in | mem_write_in)) ? BUSY : IDLE;
`ifdef EXE_OVF_TRAP_EN
      slot_ovf_d        = in_valid & alu_ovf;
`endif
    end

    if (retire) begin
      wb_valid_d = 1'b1;
      wb_wen_d   = slot_wen_q & ~slot_mem_write_q & ~retire_trap;
      wb_waddr_d = slot_waddr_q;
      wb_data_d  = (slot_mem_to_reg_q & ~slot_mem_write_q) ? dmem_rdata : slot_result_q;
`ifdef EXE_OVF_TRAP_EN
      ovf_d      = ovf_q | slot_ovf_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      slot_valid_q      <= 1'b0;
      slot_wen_q        <= 1'b0;
      slot_mem_to_reg_q <= 1'b0;
      slot_mem_write_q  <= 1'b0;
      slot_result_q     <= '0;
      slot_rdata2_q     <= '0;
      slot_waddr_q      <= '0;
      squash_q          <= 1'b0;
      branch_taken_q    <= 1'b0;
      branch_target_q   <= '0;
      wb_valid_q        <= 1'b0;
      wb_wen_q          <= 1'b0;
      wb_waddr_q        <= '0;
      wb_data_q         <= '0;
`ifdef EXE_OVF_TRAP_EN
      slot_ovf_q        <= 1'b0;
      ovf_q             <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      slot_valid_q      <= slot_valid_d;
      slot_wen_q        <= slot_wen_d;
      slot_mem_to_reg_q <= slot_mem_to_reg_d;
      slot_mem_write_q  <= slot_mem_write_d;
      slot_result_q     <= slot_result_d;
      slot_rdata2_q     <= slot_rdata2_d;
      slot_waddr_q      <= slot_waddr_d;
      squash_q          <= squash_d;
      branch_taken_q    <= branch_taken_d;
      branch_target_q   <= branch_target_d;
      wb_valid_q        <= wb_valid_d;
      wb_wen_q          <= wb_wen_d;
      wb_waddr_q        <= wb_waddr_d;
      wb_data_q         <= wb_data_d;
`ifdef EXE_OVF_TRAP_EN
      slot_ovf_q        <= slot_ovf_d;
      ovf_q             <= ovf_d;
`endif
    end
  end

  assign branch_taken_out  = branch_taken_q;
  assign branch_target_out = branch_target_q;
  assign wb_valid          = wb_valid_q;
  assign wb_wen            = wb_wen_q;
  assign wb_waddr          = wb_waddr_q;
  assign wb_data           = wb_data_q;

`ifdef EXE_OVF_TRAP_EN
  assign ovf_out = ovf_q;
`else
  assign ovf_out = 1'b0;
`endif

endmodule

// File: doc/exe_mem_stage.md
# exe_mem_stage

Execute stage plus EX/MEM pipeline slot for the miCPU pipeline. Consumes the registered ID/EX outputs, performs the ALU operation, resolves branches, and holds the instruction in a one-entry slot. Load/store instructions issue a request/acknowledge transaction to data memory and stall the upstream pipeline until it completes. Retired results are presented as registered write-back outputs.

## Interface
- DSIZE, default `DSIZE` from define.v: data width
- ISIZE, default `ISIZE` from define.v: instruction address width
- ASIZE, default `ASIZE` from define.v: register address width
- Reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  ID/EX holds a real instruction
- wen_in, branch_in, mem_to_reg_in, mem_write_in, mem_read_in  in  1 each  ID/EX control bits
- nPC_in  in  ISIZE  PC+1 of instruction
- imm_extended_in  in  DSIZE  sign-extended immediate
- alu_in1, alu_in2  in  DSIZE  ALU operands
- rdata2_in  in  DSIZE  store data
- opcode_in  in  3  ALU operation
- waddr_in  in  ASIZE  destination register
- stall_out  out  1  hold IF/ID and ID/EX (combinational)
- branch_taken_out  out  1  one-cycle taken pulse; flushes IF/ID
- branch_target_out  out  ISIZE  nPC + imm, valid with pulse
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr, dmem_wdata  out  DSIZE  address, store data
- dmem_ack  in  1  request completes this cycle
- dmem_rdata  in  DSIZE  load data, valid with ack
- wb_valid, wb_wen  out  1  write-back strobe, register write enable
- wb_waddr  out  ASIZE; wb_data  out  DSIZE
- ovf_out  out  1  overflow flag (macro only; tied 0 otherwise)

## Operation
- ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1/0), 110 SLL, 111 SRL; shift amount = alu_in2[3:0]; results truncated to DSIZE.
- Capture: on each edge with stall_out=0, slot ← {valid_in & ~squash, controls, ALU result, rdata2_in, waddr_in}.
- Branch: taken = valid & branch_in & (result == 0). Registered at capture edge: branch_taken_out=1 and branch_target_out = nPC_in + imm_extended_in[ISIZE-1:0] (mod 2^ISIZE) for exactly one cycle. squash=1 during that cycle, so the wrong-path instruction captured at the next edge is invalidated.
- FSM states IDLE, BUSY. IDLE→BUSY on capture of valid instruction with mem_read|mem_write. BUSY→IDLE on edge sampling dmem_ack=1 (or BUSY remains if a new mem instruction is captured at that same edge).
- BUSY: dmem_req=1, dmem_addr=slot result, dmem_wdata=slot rdata2, dmem_we=slot mem_write. Both read and write set: treated as write.
- stall_out = BUSY & ~dmem_ack.
- Retire: non-mem valid slot retires on the edge after capture; mem slot retires on the ack edge. Retire edge loads wb_valid=1, wb_wen=slot wen, wb_waddr, wb_data = mem_to_reg ? dmem_rdata : result. Stores retire with wb_wen forced 0. Otherwise wb_valid=0 next cycle.
- Invalid slot: no request, no retire, no branch.
- dmem_ack while IDLE ignored.

## Timing
- Reset values: all outputs 0, FSM IDLE, slot invalid, squash 0. Reset mid-transaction drops dmem_req immediately; transaction abandoned.
- ALU op: capture edge N, wb_valid high cycle N+1..N+2.
- Load/store: capture edge N, dmem_req high from N; ack sampled at edge M ≥ N+1; wb at M. Zero bubbles: next instruction captured at edge M.
- Single-cycle ack (ack=1 in first BUSY cycle): stall_out never asserts.
- Branch pulse width exactly one cycle, even under stall.

## Configuration
- EXE_OVF_TRAP_EN defined: signed overflow on ADD/SUB sets ovf_out=1 (sticky until reset) and forces wb_wen=0 for that instruction.
- Undefined: wraps silently, ovf_out tied 0.

## Test plan
- Reset: assert rst_n=0 mid-BUSY -> all outputs 0 same cycle, dmem_req drops.
- ADD 0x0003+0x0004, waddr 5, wen 1 -> wb_data 0x0007, wb_waddr 5, wb_valid one cycle after capture.
- Load alu_in1 0x0010+imm operand 0x0002, ack after 3 cycles, rdata 0xBEEF -> dmem_addr 0x0012, stall_out high 2 cycles, wb_data 0xBEEF.
- Store with same-cycle ack -> stall_out stays 0, dmem_we 1, wb_valid 1 with wb_wen 0.
- Branch SUB 5-5, nPC 0x0008, imm 0x0004 -> branch_taken_out pulse, target 0x000C, next captured instruction produces no wb_valid.
- With EXE_OVF_TRAP_EN, ADD 0x7FFF+0x0001 (DSIZE 16) -> ovf_out 1, wb_wen 0.
